// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready handshake bundle between the FIFO controller and its
// upstream producer and downstream consumer.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Environment side: drives the producer and consumer halves.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Controller side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapped around an external 64x8 dual-port RAM.
// Port 1 writes, port 2 reads with one cycle of registered latency; the
// read address is driven look-ahead so the head word is fall-through.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  ram_fifo_ctrl_if.slave    bus,
  output logic [DATA_W-1:0] o_ram_data1,
  output logic [ADDR_W-1:0] o_ram_addr1,
  output logic              o_ram_we1,
  output logic [ADDR_W-1:0] o_ram_addr2,
  output logic              o_ram_we2,
  input  logic [DATA_W-1:0] i_ram_q2,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_stale;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_out_valid;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;

  // Handshake decode and look-ahead read address.
  always_comb begin
    w_full       = (r_count == CNT_W'(DEPTH));
    w_empty      = (r_count == '0);
    // A word just written into the slot being read comes back old from the
    // RAM, so the head is withheld for one cycle until it is re-read.
    w_out_valid  = !w_empty && !r_stale;
    // Keep the RAM from being written while reset is held.
    w_push       = bus.in_valid && !w_full && !rst;
    w_pop        = w_out_valid && bus.out_ready;
    w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(w_pop);
  end

  // Pointer, occupancy and collision-flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stale  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_stale  <= w_push && (r_wr_ptr == w_rd_ptr_nxt);
    end
  end

  // Output drive to the handshake bus and the RAM.
  always_comb begin
    bus.in_ready  = !w_full;
    bus.out_valid = w_out_valid;
    bus.out_data  = i_ram_q2;
    o_ram_data1   = bus.in_data;
    o_ram_addr1   = r_wr_ptr;
    o_ram_we1     = w_push;
    o_ram_addr2   = w_rd_ptr_nxt;
    o_ram_we2     = 1'b0;
    o_count       = r_count;
    o_full        = w_full;
    o_empty       = w_empty;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: a behavioural 64x8 RAM plus a
// queue-based reference model of the FIFO's visible behaviour.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] w_ram_data1;
  logic [5:0] w_ram_addr1;
  logic       w_ram_we1;
  logic [5:0] w_ram_addr2;
  logic       w_ram_we2;
  logic [7:0] r_ram_q2;
  logic [6:0] w_count;
  logic       w_full;
  logic       w_empty;

  logic [7:0] mem [64];

  ram_fifo_ctrl_if #(.DATA_W(8)) u_if ();

  ram_fifo_ctrl #(
    .DATA_W(8),
    .ADDR_W(6)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if.slave),
    .o_ram_data1(w_ram_data1),
    .o_ram_addr1(w_ram_addr1),
    .o_ram_we1  (w_ram_we1),
    .o_ram_addr2(w_ram_addr2),
    .o_ram_we2  (w_ram_we2),
    .i_ram_q2   (r_ram_q2),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: registered read returning old data on same-address write.
  always_ff @(posedge clk) begin
    if (w_ram_we1) mem[w_ram_addr1] <= w_ram_data1;
    r_ram_q2 <= mem[w_ram_addr2];
  end

  // Reference model: queue contents plus "head just landed in empty queue".
  logic [7:0] q [$];
  bit         m_stale;
  int         n_total;
  int         n_bad;
  int         obs_pops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_valid();
    return (q.size() != 0) && !m_stale;
  endfunction

  task automatic check_outs();
    check("out_valid", 32'(u_if.out_valid), 32'(exp_valid()));
    check("count", 32'(w_count), 32'(q.size()));
    check("full", 32'(w_full), 32'(q.size() == 64));
    check("empty", 32'(w_empty), 32'(q.size() == 0));
    check("in_ready", 32'(u_if.in_ready), 32'(q.size() < 64));
    check("we2", 32'(w_ram_we2), 32'd0);
    if (exp_valid()) check("out_data", 32'(u_if.out_data), 32'(q[0]));
  endtask

  // One clock: drive at negedge, apply rules at posedge, check at next negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r);
    bit p;
    bit pp;
    u_if.in_valid  = v;
    u_if.in_data   = d;
    u_if.out_ready = r;
    p  = v && (q.size() < 64);
    pp = r && exp_valid();
    #1;
    check("we1", 32'(w_ram_we1), 32'(p));
    if (u_if.out_valid && r) obs_pops++;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    m_stale = p && (q.size() == 0);
    if (p) q.push_back(d);
    @(negedge clk);
    check_outs();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drained", 32'(w_empty), 32'd1);
  endtask

  initial begin
    int pushed;
    int cyc;
    n_total  = 0;
    n_bad    = 0;
    obs_pops = 0;
    m_stale  = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = 8'h00;
    u_if.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outs();

    // Single word: two cycles of latency, then pop back to empty.
    cycle(1'b1, 8'hA5, 1'b0);
    check("a5_lat0", 32'(u_if.out_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("a5_lat1", 32'(u_if.out_valid), 32'd1);
    check("a5_data", 32'(u_if.out_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    check("a5_empty", 32'(w_empty), 32'd1);

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(w_full), 32'd1);
    cycle(1'b1, 8'hEE, 1'b0);
    check("fill_65th", 32'(w_count), 32'd64);
    drain();

    // Streaming: 200 words, pointers wrap three times.
    obs_pops = 0;
    for (int i = 0; i < 200; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b1);
    check("stream_pops", 32'(obs_pops), 32'd198);
    drain();

    // Push into a one-word queue while popping its head.
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1);
    check("col_gap", 32'(u_if.out_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("col_back", 32'(u_if.out_valid), 32'd1);
    check("col_data", 32'(u_if.out_data), 32'h3C);
    drain();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    u_if.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_count", 32'(w_count), 32'd0);
    check("rst_empty", 32'(w_empty), 32'd1);
    check("rst_valid", 32'(u_if.out_valid), 32'd0);
    q.delete();
    m_stale = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_outs();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("rst_data", 32'(u_if.out_data), 32'h11);
    drain();

    // Random throttling on both sides.
    pushed = 0;
    cyc    = 0;
    while (pushed < 10000 && cyc < 40000) begin
      bit v;
      bit r;
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(3) != 0);
      if (v && q.size() < 64) pushed++;
      cycle(v, 8'($urandom), r);
      cyc++;
    end
    check("rand_pushed", 32'(pushed), 32'd10000);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
